// File: rtl/span_walker.sv
// Span sequencer: walks an external loadable up/down X counter from x_start to x_end, one pixel per cycle.
// Optional SPAN_WALKER_STATS_EN adds a saturating completed-span counter (span_done_count).
module span_walker #(
  parameter int BITS   = 8,
  parameter int Y_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              span_valid,
  output logic              span_ready,
  input  logic [BITS-1:0]   span_x_start,
  input  logic [BITS-1:0]   span_x_end,
  input  logic [Y_BITS-1:0] span_y,
  input  logic [BITS-1:0]   cnt_count,
  output logic              cnt_load,
  output logic [BITS-1:0]   cnt_data,
  output logic              cnt_enable,
  output logic              cnt_inverse,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [BITS-1:0]   pix_x,
  output logic [Y_BITS-1:0] pix_y,
  output logic              pix_last,
  output logic              busy
`ifdef SPAN_WALKER_STATS_EN
  ,
  output logic [15:0]       span_done_count
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [BITS-1:0]   x_end_q;
  logic [Y_BITS-1:0] y_q;
  logic              dir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Direction is fixed at acceptance so the counter always heads towards x_end and never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_end_q <= '0;
      y_q     <= '0;
      dir_q   <= 1'b0;
    end else if (state_q == IDLE && span_valid) begin
      x_end_q <= span_x_end;
      y_q     <= span_y;
      dir_q   <= (span_x_end < span_x_start);
    end
  end

  always_comb begin
    state_d     = state_q;
    span_ready  = 1'b0;
    busy        = 1'b0;
    pix_valid   = 1'b0;
    pix_last    = 1'b0;
    cnt_load    = 1'b0;
    cnt_data    = '0;
    cnt_enable  = 1'b0;
    cnt_inverse = 1'b0;
    case (state_q)
      IDLE: begin
        span_ready = 1'b1;
        cnt_load   = span_valid;
        cnt_data   = span_x_start;
        if (span_valid) state_d = RUN;
      end
      RUN: begin
        busy        = 1'b1;
        pix_valid   = 1'b1;
        pix_last    = (cnt_count == x_end_q);
        cnt_inverse = dir_q;
        cnt_enable  = pix_ready && !pix_last;
        if (pix_ready && pix_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The IDLE decode passes span inputs straight through; hold them off while reset is asserted.
    if (reset) begin
      span_ready = 1'b0;
      cnt_load   = 1'b0;
      cnt_data   = '0;
    end
  end

  assign pix_x = cnt_count;
  assign pix_y = y_q;

`ifdef SPAN_WALKER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      span_done_count <= '0;
    else if (state_q == RUN && pix_ready && pix_last && span_done_count != 16'hFFFF)
      span_done_count <= span_done_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_span_walker.sv
// Self-checking bench for span_walker: directed span table, hand-written reset sequence and random spans
// against a behavioural pixel-sequence model, with a behavioural X counter closing the loop.
module tb_span_walker;

  localparam int BITS   = 8;
  localparam int Y_BITS = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              span_valid;
  logic              span_ready;
  logic [BITS-1:0]   span_x_start;
  logic [BITS-1:0]   span_x_end;
  logic [Y_BITS-1:0] span_y;
  logic [BITS-1:0]   cnt_count;
  logic              cnt_load;
  logic [BITS-1:0]   cnt_data;
  logic              cnt_enable;
  logic              cnt_inverse;
  logic              pix_valid;
  logic              pix_ready;
  logic [BITS-1:0]   pix_x;
  logic [Y_BITS-1:0] pix_y;
  logic              pix_last;
  logic              busy;
`ifdef SPAN_WALKER_STATS_EN
  logic [15:0]       span_done_count;
`endif

  int checks   = 0;
  int failures = 0;
  int doneModel = 0;

  span_walker #(.BITS(BITS), .Y_BITS(Y_BITS)) dut (
    .clk(clk), .reset(reset),
    .span_valid(span_valid), .span_ready(span_ready),
    .span_x_start(span_x_start), .span_x_end(span_x_end), .span_y(span_y),
    .cnt_count(cnt_count), .cnt_load(cnt_load), .cnt_data(cnt_data),
    .cnt_enable(cnt_enable), .cnt_inverse(cnt_inverse),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .busy(busy)
`ifdef SPAN_WALKER_STATS_EN
    , .span_done_count(span_done_count)
`endif
  );

  always #5 clk = ~clk;

  // Loadable up/down X counter that the walker drives; its synchronous reset shares the reset net.
  always @(posedge clk) begin
    if (reset)           cnt_count <= '0;
    else if (cnt_load)   cnt_count <= cnt_data;
    else if (cnt_enable) cnt_count <= cnt_inverse ? cnt_count - 1'b1 : cnt_count + 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input int xs, input int xe, input int y, input logic rdy);
    span_valid   = v;
    span_x_start = BITS'(xs);
    span_x_end   = BITS'(xe);
    span_y       = Y_BITS'(y);
    pix_ready    = rdy;
  endtask

  task automatic checkStats();
`ifdef SPAN_WALKER_STATS_EN
    checkOutput("span_done_count", 32'(span_done_count), 32'(doneModel));
`endif
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1,1,0,1...; 2: random ready plus junk requests during RUN.
  task automatic runSpan(input int xs, input int xe, input int y, input int mode,
                         output int accepted, output int lastX);
    int  n, dir, idx, cyc, expX;
    logic rdy, last;
    int  pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    n   = (xe >= xs) ? xe - xs + 1 : xs - xe + 1;
    dir = (xe < xs) ? 1 : 0;
    accepted = 0;
    lastX    = -1;
    applyStimulus(1'b1, xs, xe, y, 1'b0);
    #1;
    checkOutput("idle_span_ready", 32'(span_ready), 1);
    checkOutput("idle_cnt_load", 32'(cnt_load), 1);
    checkOutput("idle_cnt_data", 32'(cnt_data), 32'(xs));
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_pix_valid", 32'(pix_valid), 0);
    @(posedge clk); #1;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 4 * n + 20) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 7] != 0;
        default: rdy = $urandom_range(0, 1) != 0;
      endcase
      if (mode == 2)
        applyStimulus($urandom_range(0, 1) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), rdy);
      else
        applyStimulus(1'b0, xs, xe, y, rdy);
      #1;
      expX = dir ? xs - idx : xs + idx;
      last = (idx == n - 1);
      checkOutput("run_pix_valid", 32'(pix_valid), 1);
      checkOutput("run_busy", 32'(busy), 1);
      checkOutput("run_span_ready", 32'(span_ready), 0);
      checkOutput("run_cnt_load", 32'(cnt_load), 0);
      checkOutput("run_pix_x", 32'(pix_x), 32'(expX));
      checkOutput("run_pix_y", 32'(pix_y), 32'(y));
      checkOutput("run_pix_last", 32'(pix_last), 32'(last));
      checkOutput("run_cnt_enable", 32'(cnt_enable), 32'(rdy && !last));
      checkOutput("run_cnt_inverse", 32'(cnt_inverse), 32'(dir));
      if (pix_valid && rdy) begin
        accepted++;
        if (pix_last) lastX = int'(pix_x);
      end
      if (rdy) begin
        if (last && doneModel < 65535) doneModel++;
        idx++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (idx < n) checkOutput("span_timeout", 32'(idx), 32'(n));
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    #1;
    checkOutput("bubble_pix_valid", 32'(pix_valid), 0);
    checkOutput("bubble_span_ready", 32'(span_ready), 1);
    checkOutput("bubble_busy", 32'(busy), 0);
    checkStats();
  endtask

  typedef struct {
    int xs;
    int xe;
    int y;
    int mode;
    int expCount;
    int expLast;
  } vec_t;

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t vecs[7];
    int   acc, lastX, xs, xe;
    vecs[0] = '{3, 7, 10, 0, 5, 7};
    vecs[1] = '{9, 5, 3, 0, 5, 5};
    vecs[2] = '{42, 42, 1, 0, 1, 42};
    vecs[3] = '{2, 6, 7, 1, 5, 6};
    vecs[4] = '{0, 255, 20, 0, 256, 255};
    vecs[5] = '{255, 0, 21, 0, 256, 0};
    vecs[6] = '{100, 90, 5, 2, 11, 90};

    reset = 1'b1;
    applyStimulus(1'b1, 5, 9, 77, 1'b1);
    #2;
    checkOutput("rst_pix_valid", 32'(pix_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_cnt_load", 32'(cnt_load), 0);
    checkOutput("rst_cnt_data", 32'(cnt_data), 0);
    checkOutput("rst_cnt_enable", 32'(cnt_enable), 0);
    checkOutput("rst_cnt_inverse", 32'(cnt_inverse), 0);
    checkOutput("rst_pix_last", 32'(pix_last), 0);
    checkOutput("rst_pix_y", 32'(pix_y), 0);
    checkStats();
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    for (int i = 0; i < 7; i++) begin
      runSpan(vecs[i].xs, vecs[i].xe, vecs[i].y, vecs[i].mode, acc, lastX);
      checkOutput($sformatf("vec%0d_count", i), 32'(acc), 32'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d_last", i), 32'(lastX), 32'(vecs[i].expLast));
    end

    // Reset arrives while the third pixel of span 10..20 is on the output.
    applyStimulus(1'b1, 10, 20, 9, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 0, 0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_third_pixel", 32'(pix_x), 12);
    reset = 1'b1;
    #1;
    doneModel = 0;
    checkOutput("midrst_pix_valid", 32'(pix_valid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_pix_last", 32'(pix_last), 0);
    checkOutput("midrst_cnt_enable", 32'(cnt_enable), 0);
    checkOutput("midrst_pix_y", 32'(pix_y), 0);
    checkStats();
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    runSpan(1, 2, 4, 0, acc, lastX);
    checkOutput("postrst_count", 32'(acc), 2);
    checkOutput("postrst_last", 32'(lastX), 2);

    for (int i = 0; i < 15; i++) begin
      xs = $urandom_range(0, 255);
      xe = $urandom_range(0, 255);
      runSpan(xs, xe, $urandom_range(0, 255), 2, acc, lastX);
      checkOutput("rand_count", 32'(acc), 32'((xe >= xs) ? xe - xs + 1 : xs - xe + 1));
      checkOutput("rand_last", 32'(lastX), 32'(xe));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
